// File: rtl/secure_mem_arbiter_pkg.sv
// Shared types and constants for the secure memory arbiter.
package mcse_mem_arb_pkg;

    // Transaction FSM: accept in IDLE, strobe memory in ISSUE, wait for
    // completion in WAIT, report to the requester in RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_PERM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Saturating 8-bit increment used by the violation counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/secure_mem_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: searches upward from last_grant+1
// with wrap-around and returns the first active request.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] cand;

    // Walk the N candidates in rotated order; the first active one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_grant) + k) % N);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/secure_mem_arbiter.sv
// Shares the single-port secure memory among NUM_REQ requesters with
// round-robin arbitration, per-address write permissions, a global
// lifecycle write lock, a completion timeout and a violation counter.
module secure_mem_arbiter
    import mcse_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned WIDTH          = 256,
    parameter int unsigned LENGTH         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned AW = $clog2(LENGTH),
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*AW-1:0]       req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [1:0]                  rsp_err,
    output logic [WIDTH-1:0]            rsp_rdata,
    input  logic [NUM_REQ*LENGTH-1:0]   perm_wr_mask,
    input  logic                        lc_wr_lock,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [AW-1:0]               mem_addr,
    output logic [WIDTH-1:0]            mem_wrData,
    input  logic [WIDTH-1:0]            mem_rdData,
    input  logic                        mem_valid,
    output logic [7:0]                  violation_count
);

    arb_state_e        state;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     gnt_q;
    logic              we_q;
    logic [CW-1:0]     tmo_cnt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic [LENGTH-1:0]  perm_row;
    logic               sel_denied;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Select the winning requester's command and evaluate its write permission.
    always_comb begin
        sel_we     = req_we[arb_idx];
        sel_addr   = req_addr[32'(arb_idx) * AW +: AW];
        sel_wdata  = req_wdata[32'(arb_idx) * WIDTH +: WIDTH];
        perm_row   = perm_wr_mask[32'(arb_idx) * LENGTH +: LENGTH];
        // Reads are never denied; writes need the per-address bit and no lock.
        sel_denied = sel_we & (lc_wr_lock | ~perm_row[sel_addr]);
    end

    // Acceptance strobe only in IDLE; gated by reset so it is 0 while held in reset.
    always_comb begin
        req_ready = '0;
        if (rst && (state == IDLE)) begin
            req_ready = arb_grant;
        end
    end

    // Transaction FSM with all memory and response outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            last_grant      <= IW'(NUM_REQ - 1);
            gnt_q           <= '0;
            we_q            <= 1'b0;
            tmo_cnt         <= '0;
            mem_rd_en       <= 1'b0;
            mem_wr_en       <= 1'b0;
            mem_addr        <= '0;
            mem_wrData      <= '0;
            rsp_valid       <= '0;
            rsp_err         <= ERR_OK;
            rsp_rdata       <= '0;
            violation_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q <= arb_idx;
                        we_q  <= sel_we;
                        if (sel_denied) begin
                            // Denied writes never touch memory.
                            state           <= RESP;
                            rsp_valid       <= arb_grant;
                            rsp_err         <= ERR_PERM;
                            rsp_rdata       <= '0;
                            violation_count <= sat_inc8(violation_count);
                        end else begin
                            state      <= ISSUE;
                            mem_rd_en  <= ~sel_we;
                            mem_wr_en  <= sel_we;
                            mem_addr   <= sel_addr;
                            mem_wrData <= sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd_en  <= 1'b0;
                    mem_wr_en  <= 1'b0;
                    mem_addr   <= '0;
                    mem_wrData <= '0;
                    tmo_cnt    <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // mem_valid takes priority over the final timeout cycle.
                    if (mem_valid) begin
                        state     <= RESP;
                        rsp_valid <= NUM_REQ'(1) << gnt_q;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= we_q ? '0 : mem_rdData;
                    end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // This is the TIMEOUT_CYCLES-th WAIT cycle without completion.
                        state     <= RESP;
                        rsp_valid <= NUM_REQ'(1) << gnt_q;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid  <= '0;
                    rsp_err    <= ERR_OK;
                    rsp_rdata  <= '0;
                    last_grant <= gnt_q;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secure_mem_arbiter.sv
// Self-checking bench for secure_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_secure_mem_arbiter;
    import mcse_mem_arb_pkg::*;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned WIDTH   = 256;
    localparam int unsigned LENGTH  = 16;
    localparam int unsigned TMO     = 64;
    localparam int unsigned AW      = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*AW-1:0]     req_addr;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [1:0]                rsp_err;
    logic [WIDTH-1:0]          rsp_rdata;
    logic [NUM_REQ*LENGTH-1:0] perm_wr_mask;
    logic                      lc_wr_lock;
    logic                      mem_rd_en;
    logic                      mem_wr_en;
    logic [AW-1:0]             mem_addr;
    logic [WIDTH-1:0]          mem_wrData;
    logic [WIDTH-1:0]          mem_rdData;
    logic                      mem_valid;
    logic [7:0]                violation_count;

    always #5 clk = ~clk;

    secure_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .perm_wr_mask(perm_wr_mask), .lc_wr_lock(lc_wr_lock),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wrData(mem_wrData), .mem_rdData(mem_rdData), .mem_valid(mem_valid),
        .violation_count(violation_count)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] init_word(input int i);
        logic [7:0] b;
        b = {4'hA, 4'(i)};
        return {32{b}};
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] d;
        for (int w = 0; w < WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    // Memory stand-in: configurable latency, or silent to provoke timeouts.
    logic [WIDTH-1:0] memarr [LENGTH];
    int               mem_lat    = 1;
    logic             mem_silent = 1'b0;
    int               pend_cnt;
    logic             p_we;
    logic [AW-1:0]    p_addr;
    logic [WIDTH-1:0] p_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid  <= 1'b0;
            mem_rdData <= '0;
            pend_cnt   <= 0;
            for (int i = 0; i < LENGTH; i++) memarr[i] <= init_word(i);
        end else begin
            mem_valid  <= 1'b0;
            mem_rdData <= '0;
            if ((mem_rd_en || mem_wr_en) && !mem_silent) begin
                if (mem_lat <= 1) begin
                    mem_valid <= 1'b1;
                    if (mem_wr_en) memarr[mem_addr] <= mem_wrData;
                    else mem_rdData <= memarr[mem_addr];
                end else begin
                    pend_cnt <= mem_lat - 1;
                    p_we     <= mem_wr_en;
                    p_addr   <= mem_addr;
                    p_data   <= mem_wrData;
                end
            end else if (pend_cnt == 1) begin
                mem_valid <= 1'b1;
                if (p_we) memarr[p_addr] <= p_data;
                else mem_rdData <= memarr[p_addr];
                pend_cnt <= 0;
            end else if (pend_cnt > 1) begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // Requester-side stimulus state.
    logic             vld    [NUM_REQ];
    logic             we_v   [NUM_REQ];
    logic [AW-1:0]    addr_v [NUM_REQ];
    logic [WIDTH-1:0] data_v [NUM_REQ];

    task automatic apply_req();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i +: 1]           = vld[i];
            req_we[i +: 1]              = we_v[i];
            req_addr[i*AW +: AW]        = addr_v[i];
            req_wdata[i*WIDTH +: WIDTH] = data_v[i];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, WIDTH'(req_ready), '0);
        check_eq({tag, "_rspv"}, WIDTH'(rsp_valid), '0);
        check_eq({tag, "_err"}, WIDTH'(rsp_err), '0);
        check_eq({tag, "_rdata"}, rsp_rdata, '0);
        check_eq({tag, "_rd_en"}, WIDTH'(mem_rd_en), '0);
        check_eq({tag, "_wr_en"}, WIDTH'(mem_wr_en), '0);
        check_eq({tag, "_addr"}, WIDTH'(mem_addr), '0);
        check_eq({tag, "_wdata"}, mem_wrData, '0);
        check_eq({tag, "_viol"}, WIDTH'(violation_count), '0);
    endtask

    // One isolated transaction; lat = cycles from acceptance (T) to rsp_valid.
    task automatic run_txn(input int r, input logic we, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d, output logic [1:0] err,
                           output logic [WIDTH-1:0] rdata, output int lat,
                           output int n_rd, output int n_wr);
        int k;
        err = '0; rdata = '0; lat = 0; n_rd = 0; n_wr = 0;
        @(negedge clk);
        vld[r] = 1'b1; we_v[r] = we; addr_v[r] = a; data_v[r] = d;
        apply_req();
        #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check_eq("grant", WIDTH'(req_ready), WIDTH'(oh(r)));
        vld[r] = 1'b0;
        if (req_ready == '0) begin
            apply_req();
            return;
        end
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            apply_req();
            #1;
            lat++;
            if (mem_rd_en) n_rd++;
            if (mem_wr_en) n_wr++;
            if (rsp_valid != '0) break;
            k++;
        end
        check_eq("rsp_who", WIDTH'(rsp_valid), WIDTH'(oh(r)));
        err   = rsp_err;
        rdata = rsp_rdata;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [1:0]       e;
        logic [WIDTH-1:0] rd;
        logic [WIDTH-1:0] wd;
        int               lat, nrd, nwr;
        int               who [4];
        int               at  [4];
        int               nr;
        // reference model state
        logic [WIDTH-1:0] ref_mem [LENGTH];
        int               ref_last, ref_viol, exp_r, exp_g, grant_cyc, free_cyc;
        logic [1:0]       exp_err;
        logic [WIDTH-1:0] exp_rdata;
        logic             busy;

        // ---- reset with all requesters pending, then contention ----
        for (int i = 0; i < NUM_REQ; i++) begin
            vld[i] = 1'b1; we_v[i] = 1'b0; addr_v[i] = AW'(i); data_v[i] = '0;
        end
        apply_req();
        perm_wr_mask = '1;
        lc_wr_lock   = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        nr = 0;
        for (int q = 0; q < 4; q++) begin who[q] = 0; at[q] = 0; end
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (rsp_valid != '0 && nr < 4) begin
                who[nr] = int'(rsp_valid); at[nr] = c; nr++;
            end
        end
        check_eq("cont_who0", WIDTH'(who[0]), WIDTH'(1));
        check_eq("cont_who1", WIDTH'(who[1]), WIDTH'(2));
        check_eq("cont_who2", WIDTH'(who[2]), WIDTH'(4));
        check_eq("cont_who3", WIDTH'(who[3]), WIDTH'(1));
        check_eq("cont_first", WIDTH'(at[0]), WIDTH'(3));
        for (int q = 1; q < 4; q++) check_eq("cont_gap", WIDTH'(at[q] - at[q-1]), WIDTH'(4));
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) vld[i] = 1'b0;
        apply_req();
        repeat (6) @(negedge clk);

        // ---- single read ----
        run_txn(0, 1'b0, 4'd5, '0, e, rd, lat, nrd, nwr);
        check_eq("rd_lat", WIDTH'(lat), WIDTH'(3));
        check_eq("rd_nrd", WIDTH'(nrd), WIDTH'(1));
        check_eq("rd_nwr", WIDTH'(nwr), '0);
        check_eq("rd_err", WIDTH'(e), WIDTH'(ERR_OK));
        check_eq("rd_data", rd, {32{8'hA5}});

        // ---- permissions ----
        perm_wr_mask = '1;
        perm_wr_mask[1*LENGTH + 3 +: 1] = 1'b0;
        run_txn(1, 1'b1, 4'd3, rand_word(), e, rd, lat, nrd, nwr);
        check_eq("perm_err", WIDTH'(e), WIDTH'(ERR_PERM));
        check_eq("perm_nwr", WIDTH'(nwr), '0);
        check_eq("perm_lat", WIDTH'(lat), WIDTH'(1));
        check_eq("perm_rdata", rd, '0);
        check_eq("perm_viol", WIDTH'(violation_count), WIDTH'(1));
        lc_wr_lock = 1'b1;
        run_txn(0, 1'b1, 4'd0, rand_word(), e, rd, lat, nrd, nwr);
        check_eq("lock_err", WIDTH'(e), WIDTH'(ERR_PERM));
        check_eq("lock_nwr", WIDTH'(nwr), '0);
        check_eq("lock_viol", WIDTH'(violation_count), WIDTH'(2));
        run_txn(0, 1'b0, 4'd0, '0, e, rd, lat, nrd, nwr);
        check_eq("lock_rd_err", WIDTH'(e), WIDTH'(ERR_OK));
        check_eq("lock_rd_data", rd, init_word(0));
        lc_wr_lock = 1'b0;
        wd = rand_word();
        run_txn(2, 1'b1, 4'd7, wd, e, rd, lat, nrd, nwr);
        check_eq("wr_err", WIDTH'(e), WIDTH'(ERR_OK));
        check_eq("wr_nwr", WIDTH'(nwr), WIDTH'(1));
        check_eq("wr_lat", WIDTH'(lat), WIDTH'(3));
        check_eq("wr_rdata", rd, '0);
        run_txn(1, 1'b0, 4'd7, '0, e, rd, lat, nrd, nwr);
        check_eq("wr_readback", rd, wd);

        // ---- timeout and the mem_valid-vs-limit boundary ----
        mem_silent = 1'b1;
        run_txn(1, 1'b0, 4'd2, '0, e, rd, lat, nrd, nwr);
        check_eq("tmo_lat", WIDTH'(lat), WIDTH'(TMO + 2));
        check_eq("tmo_err", WIDTH'(e), WIDTH'(ERR_TIMEOUT));
        check_eq("tmo_rdata", rd, '0);
        mem_silent = 1'b0;
        run_txn(1, 1'b0, 4'd2, '0, e, rd, lat, nrd, nwr);
        check_eq("post_tmo_lat", WIDTH'(lat), WIDTH'(3));
        check_eq("post_tmo_data", rd, init_word(2));
        mem_lat = TMO;
        run_txn(0, 1'b0, 4'd4, '0, e, rd, lat, nrd, nwr);
        check_eq("edge_err", WIDTH'(e), WIDTH'(ERR_OK));
        check_eq("edge_lat", WIDTH'(lat), WIDTH'(TMO + 2));
        check_eq("edge_data", rd, init_word(4));
        // completion one cycle late: timeout, then the stray mem_valid is ignored
        mem_lat = TMO + 1;
        run_txn(0, 1'b0, 4'd4, '0, e, rd, lat, nrd, nwr);
        check_eq("late_err", WIDTH'(e), WIDTH'(ERR_TIMEOUT));
        check_eq("late_rdata", rd, '0);
        mem_lat = 1;
        run_txn(2, 1'b0, 4'd6, '0, e, rd, lat, nrd, nwr);
        check_eq("after_late_err", WIDTH'(e), WIDTH'(ERR_OK));
        check_eq("after_late_data", rd, init_word(6));

        // ---- violation counter saturation ----
        lc_wr_lock = 1'b1;
        for (int n = 0; n < 260; n++) begin
            run_txn(n % NUM_REQ, 1'b1, AW'(n), rand_word(), e, rd, lat, nrd, nwr);
            if (n == 251) check_eq("sat_254", WIDTH'(violation_count), WIDTH'(254));
            if (n == 252) check_eq("sat_255", WIDTH'(violation_count), WIDTH'(255));
        end
        check_eq("sat_hold", WIDTH'(violation_count), WIDTH'(255));
        check_eq("sat_err", WIDTH'(e), WIDTH'(ERR_PERM));
        lc_wr_lock = 1'b0;

        // ---- reset while waiting for memory ----
        mem_silent = 1'b1;
        @(negedge clk);
        vld[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 4'd1;
        apply_req();
        #1;
        check_eq("mid_grant", WIDTH'(req_ready), WIDTH'(oh(0)));
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check_eq("mid_rst_rspv", WIDTH'(rsp_valid), '0);
        end
        @(negedge clk);
        vld[0] = 1'b0;
        apply_req();
        mem_silent = 1'b0;
        rst = 1'b1;
        run_txn(2, 1'b0, 4'd9, '0, e, rd, lat, nrd, nwr);
        check_eq("mid_after_lat", WIDTH'(lat), WIDTH'(3));
        check_eq("mid_after_data", rd, init_word(9));

        // ---- randomized traffic against the reference model ----
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < LENGTH; i++) ref_mem[i] = init_word(i);
        ref_last = NUM_REQ - 1; ref_viol = 0; busy = 1'b0;
        exp_r = 0; exp_err = '0; exp_rdata = '0; grant_cyc = 0; free_cyc = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!vld[i] && $urandom_range(0, 3) == 0) begin
                    vld[i] = 1'b1; we_v[i] = 1'($urandom_range(0, 1));
                    addr_v[i] = AW'($urandom_range(0, LENGTH - 1)); data_v[i] = rand_word();
                end
            end
            perm_wr_mask = {16'($urandom), $urandom};
            lc_wr_lock   = ($urandom_range(0, 7) == 0);
            mem_lat      = int'($urandom_range(1, 4));
            apply_req();
            #1;
            if (rsp_valid != '0) begin
                if (!busy) begin
                    check_eq("rsp_unexpected", WIDTH'(rsp_valid), '0);
                end else begin
                    check_eq("rnd_rsp_who", WIDTH'(rsp_valid), WIDTH'(oh(exp_r)));
                    check_eq("rnd_rsp_err", WIDTH'(rsp_err), WIDTH'(exp_err));
                    check_eq("rnd_rsp_rdata", rsp_rdata, exp_rdata);
                    check_eq("rnd_viol", WIDTH'(violation_count), WIDTH'(ref_viol));
                end
                busy = 1'b0;
                free_cyc = cyc + 1;
            end
            exp_g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (exp_g < 0 && vld[(ref_last + k) % NUM_REQ]) exp_g = (ref_last + k) % NUM_REQ;
            end
            if (busy || cyc < free_cyc || exp_g < 0) begin
                check_eq("rnd_no_ready", WIDTH'(req_ready), '0);
            end else begin
                check_eq("rnd_rr_grant", WIDTH'(req_ready), WIDTH'(oh(exp_g)));
                if (we_v[exp_g]) begin
                    if (lc_wr_lock || !perm_wr_mask[exp_g*LENGTH + int'(addr_v[exp_g]) +: 1]) begin
                        exp_err = ERR_PERM;
                        if (ref_viol < 255) ref_viol++;
                    end else begin
                        exp_err = ERR_OK;
                        ref_mem[addr_v[exp_g]] = data_v[exp_g];
                    end
                    exp_rdata = '0;
                end else begin
                    exp_err   = ERR_OK;
                    exp_rdata = ref_mem[addr_v[exp_g]];
                end
                ref_last  = exp_g;
                exp_r     = exp_g;
                busy      = 1'b1;
                grant_cyc = cyc;
                vld[exp_g] = 1'b0;
            end
            if (busy && cyc - grant_cyc > 20) begin
                check_eq("rsp_watchdog", WIDTH'(rsp_valid), WIDTH'(oh(exp_r)));
                busy = 1'b0;
                free_cyc = cyc + 1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) vld[i] = 1'b0;
        @(negedge clk);
        apply_req();
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
